// File: rtl/smem_pkg.sv
// rtl/smem_pkg.sv - shared defaults, state enum and requester index helpers for smem_arbiter
package smem_pkg;

  localparam int N_REQ_DEF  = 3;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    LOCKED = 2'd2
  } arb_state_e;

  // Two bits cover the supported 2..4 requesters.
  typedef logic [1:0] req_idx_t;

  // Next requester index in round-robin order, wrapping at n.
  function automatic req_idx_t idx_inc(input req_idx_t i, input int n);
    if (int'(i) + 1 >= n) return '0;
    return i + 2'd1;
  endfunction

endpackage

// File: rtl/smem_arbiter_rr_pick.sv
// rtl/smem_arbiter_rr_pick.sv - combinational rotating-priority pick starting at ptr
module rr_pick
  import smem_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0] req,
  input  req_idx_t         ptr,
  output logic [N_REQ-1:0] gnt_oh,
  output req_idx_t         gnt_idx,
  output logic             valid
);

  int       j;
  req_idx_t jj;

  // Walk requesters from ptr upward with wrap; first asserted request wins.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    valid   = 1'b0;
    j       = 0;
    jj      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      jj = req_idx_t'(j);
      if (!valid && req[jj]) begin
        valid      = 1'b1;
        gnt_idx    = jj;
        gnt_oh[jj] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/smem_arbiter.sv
// rtl/smem_arbiter.sv - round-robin S-memory port arbiter with optional lock (SMEM_ARB_LOCK_EN)
module smem_arbiter
  import smem_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          lock,
  input  logic [N_REQ-1:0]          wr,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         address,
  output logic [DATA_W-1:0]         data,
  output logic                      wren,
  input  logic [DATA_W-1:0]         q
);

`ifdef SMEM_ARB_LOCK_EN
  localparam logic LockEn = 1'b1;
`else
  localparam logic LockEn = 1'b0;
`endif

  arb_state_e        state_q, state_d;
  req_idx_t          rr_ptr_q, rr_ptr_d;
  req_idx_t          owner_q, owner_d;
  logic [N_REQ-1:0]  rvalid_q, rvalid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic [N_REQ-1:0]  pick_oh;
  req_idx_t          pick_idx;
  logic              pick_valid;

  logic [N_REQ-1:0]  gnt_c;
  req_idx_t          sel_idx;
  logic              sel_valid;
  logic              take_lock;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req     (req),
    .ptr     (rr_ptr_q),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .valid   (pick_valid)
  );

  // Grant selection, lock handling, round-robin pointer update and port mux.
  always_comb begin
    sel_valid = pick_valid;
    sel_idx   = pick_idx;
    gnt_c     = pick_oh;
    if (state_q == LOCKED) begin
      // Owner keeps the port; everyone else stalls, even the cycle the owner lets go.
      sel_idx        = owner_q;
      sel_valid      = req[owner_q];
      gnt_c          = '0;
      gnt_c[owner_q] = req[owner_q];
    end
    if (reset) begin
      sel_valid = 1'b0;
      gnt_c     = '0;
    end

    take_lock = sel_valid & lock[sel_idx] & LockEn;

    state_d  = IDLE;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    if (take_lock) begin
      state_d = LOCKED;
      owner_d = sel_idx;
    end else if (sel_valid) begin
      state_d  = BUSY;
      rr_ptr_d = idx_inc(sel_idx, N_REQ);
    end else if (state_q == LOCKED) begin
      rr_ptr_d = idx_inc(owner_q, N_REQ);
    end

    addr_d   = addr_q;
    data_d   = data_q;
    rvalid_d = '0;
    wren     = 1'b0;
    if (sel_valid) begin
      addr_d = req_addr[int'(sel_idx)*ADDR_W +: ADDR_W];
      data_d = req_wdata[int'(sel_idx)*DATA_W +: DATA_W];
      wren   = wr[sel_idx];
      if (!wr[sel_idx]) rvalid_d[sel_idx] = 1'b1;
    end
  end

  assign gnt     = gnt_c;
  assign address = addr_d;
  assign data    = data_d;
  assign rvalid  = rvalid_q;
  // RAM output is only meaningful the cycle after a read grant.
  assign rdata   = (|rvalid_q) ? q : '0;

  // Arbiter state, pointer, read-valid pipeline and held memory-port values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      rvalid_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      rvalid_q <= rvalid_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: tb/tb_smem_arbiter.sv
// tb/tb_smem_arbiter.sv - directed plus randomized check of smem_arbiter against a behavioural model
module tb_smem_arbiter;

  localparam int N  = 3;
  localparam int AW = 8;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req, lock, wr;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    gnt, rvalid;
  logic [DW-1:0]   rdata, data, q;
  logic [AW-1:0]   address;
  logic            wren;

  smem_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .wr(wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid),
    .rdata(rdata), .address(address), .data(data), .wren(wren), .q(q)
  );

  always #5 clk = ~clk;

  // Single-port RAM with registered inputs, read-before-write.
  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    if (wren) ram[address] <= data;
    q <= ram[address];
  end

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state.
  bit            lock_en;
  int            m_ptr;
  bit            m_locked;
  int            m_owner;
  bit            m_pend;
  int            m_pend_idx;
  logic [DW-1:0] m_pend_data;
  logic [DW-1:0] m_mem [256];
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [DW-1:0] old_val;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_locked = 0; m_owner = 0; m_pend = 0;
    m_pend_idx = 0; m_pend_data = '0; m_addr = '0; m_data = '0;
  endtask

  // Called just after a negedge with inputs already driven: checks this cycle, advances the model.
  task automatic step(input string tag);
    int            g;
    int            idx;
    logic [N-1:0]  eg;
    logic [N-1:0]  erv;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    #1;
    g = -1;
    if (m_locked) begin
      if (req[m_owner]) g = m_owner;
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && req[idx]) g = idx;
      end
    end
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    a = (g >= 0) ? req_addr[g*AW +: AW] : m_addr;
    d = (g >= 0) ? req_wdata[g*DW +: DW] : m_data;
    erv = '0;
    if (m_pend) erv[m_pend_idx] = 1'b1;
    chk({tag, "_gnt"}, 32'(gnt), 32'(eg));
    chk({tag, "_wren"}, 32'(wren), (g >= 0) ? 32'(wr[g]) : 32'd0);
    chk({tag, "_addr"}, 32'(address), 32'(a));
    if (g >= 0 && wr[g]) chk({tag, "_data"}, 32'(data), 32'(d));
    chk({tag, "_rvalid"}, 32'(rvalid), 32'(erv));
    chk({tag, "_rdata"}, 32'(rdata), m_pend ? 32'(m_pend_data) : 32'd0);

    m_pend = 0;
    if (g >= 0) begin
      m_addr = a;
      m_data = d;
      if (wr[g]) m_mem[a] = d;
      else begin
        m_pend = 1; m_pend_idx = g; m_pend_data = m_mem[a];
      end
      if (lock_en && lock[g]) begin
        m_locked = 1; m_owner = g;
      end else begin
        m_locked = 0; m_ptr = (g + 1) % N;
      end
    end else if (m_locked) begin
      m_locked = 0; m_ptr = (m_owner + 1) % N;
    end
    @(negedge clk);
  endtask

  task automatic set_rq(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  initial begin
`ifdef SMEM_ARB_LOCK_EN
    lock_en = 1'b1;
`else
    lock_en = 1'b0;
`endif
    for (int i = 0; i < 256; i++) begin
      ram[i]   = 8'($urandom);
      m_mem[i] = ram[i];
    end
    reset = 1'b1; req = '1; lock = '0; wr = '0; req_addr = '0; req_wdata = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_wren", 32'(wren), 32'd0);
    chk("rst_addr", 32'(address), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Three-way read contention rotates 001,010,100,001.
    req = 3'b111; wr = '0; lock = '0;
    set_rq(0, 8'h10, 8'h00); set_rq(1, 8'h20, 8'h00); set_rq(2, 8'h30, 8'h00);
    #1 chk("rr_c0", 32'(gnt), 32'b001); step("rr0");
    #1 chk("rr_c1", 32'(gnt), 32'b010); chk("rr_rd0", 32'(rdata), 32'(m_mem[8'h10])); step("rr1");
    #1 chk("rr_c2", 32'(gnt), 32'b100); chk("rr_rv1", 32'(rvalid), 32'b010); step("rr2");
    #1 chk("rr_c3", 32'(gnt), 32'b001); chk("rr_rd2", 32'(rdata), 32'(m_mem[8'h30])); step("rr3");

    // Requester 1 writes then reads back.
    req = 3'b010; wr = 3'b010; set_rq(1, 8'h42, 8'hA5);
    #1 chk("wr_addr", 32'(address), 32'h42); chk("wr_data", 32'(data), 32'hA5);
    chk("wr_wren", 32'(wren), 32'd1); step("wr");
    wr = '0; step("rdb");
    req = '0; #1 chk("rdb_rvalid", 32'(rvalid), 32'b010); chk("rdb_rdata", 32'(rdata), 32'hA5);
    step("rdb_idle");

    // Read-modify-write by requester 0 while requester 2 waits.
    req = 3'b100; step("pre_lock");
    req = 3'b101; lock = 3'b001; wr = '0; set_rq(0, 8'h05, 8'h00); set_rq(2, 8'h31, 8'h00);
    old_val = m_mem[8'h05];
    #1 chk("lk_a_gnt", 32'(gnt), 32'b001); step("lk_a");
    lock = 3'b000; wr = 3'b001; set_rq(0, 8'h05, 8'h77);
`ifdef SMEM_ARB_LOCK_EN
    #1 chk("lk_b_gnt", 32'(gnt), 32'b001);
`else
    #1 chk("lk_b_gnt", 32'(gnt), 32'b100);
`endif
    chk("lk_b_rdata", 32'(rdata), 32'(old_val)); step("lk_b");
    req = 3'b100; wr = '0;
    #1 chk("lk_c_gnt", 32'(gnt), 32'b100); step("lk_c");

    // Reset right after a granted (locked) read: lock dropped, rvalid suppressed.
    req = 3'b001; lock = 3'b001; wr = '0; set_rq(0, 8'h07, 8'h00);
    step("rr_read");
    reset = 1'b1;
    #1;
    chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_wren", 32'(wren), 32'd0);
    chk("mid_rst_addr", 32'(address), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0; req = 3'b110; lock = '0;
    #1 chk("post_rst_gnt", 32'(gnt), 32'b010); chk("post_rst_rvalid", 32'(rvalid), 32'd0);
    step("post_rst");

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      req = 3'($urandom);
      wr  = 3'($urandom);
      for (int i = 0; i < N; i++) begin
        lock[i] = ($urandom_range(0, 3) == 0);
        set_rq(i, 8'($urandom_range(0, 15)), 8'($urandom));
      end
      step("rnd");
    end
    req = '0; lock = '0; wr = '0;
    step("drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/smem_arbiter.md
SMEM_ARBITER -- requirements
Module: smem_arbiter

Interface
REQ-001 SHALL have parameter: N_REQ, 3, number of requesters sharing the S-memory port (2..4).
REQ-002 SHALL have parameter: ADDR_W, 8, memory address width (256 entries).
REQ-003 SHALL have parameter: DATA_W, 8, memory data width.
REQ-004 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port: reset  input  1  asynchronous, active-high.
REQ-006 SHALL have port: req  input  N_REQ  per-requester access request.
REQ-007 SHALL have port: lock  input  N_REQ  per-requester hold-grant (read-modify-write) request.
REQ-008 SHALL have port: wr  input  N_REQ  per-requester 1=write, 0=read.
REQ-009 SHALL have port: req_addr  input  N_REQ*ADDR_W  packed per-requester addresses (requester i at slice i).
REQ-010 SHALL have port: req_wdata  input  N_REQ*DATA_W  packed per-requester write data.
REQ-011 SHALL have port: gnt  output  N_REQ  one-hot grant, at most one bit set.
REQ-012 SHALL have port: rvalid  output  N_REQ  one-hot read-data-valid.
REQ-013 SHALL have port: rdata  output  DATA_W  shared read data, qualified by rvalid.
REQ-014 SHALL have ports to memory: address output ADDR_W, data output DATA_W, wren output 1, q input DATA_W (single-port RAM, registered inputs, q valid one cycle after address sampled).

Function
REQ-015 gnt SHALL be combinational from req, state and rr pointer; granted requester's access completes at the edge ending that cycle.
REQ-016 address/data/wren SHALL mux from granted requester; with no grant wren=0, address and data hold their last driven values.
REQ-017 Arbitration SHALL be round-robin: search starts at rr_ptr, first i with req[i] wins; after a non-locked grant to i, rr_ptr=(i+1) mod N_REQ.
REQ-018 For a granted read at cycle T, rvalid[i]=1 and rdata=q SHALL hold in cycle T+1 only; a write SHALL produce no rvalid.
REQ-019 States SHALL be IDLE (no grant), BUSY (non-locked grant this cycle), LOCKED (owner retains port).
REQ-020 Transitions: IDLE/BUSY -> LOCKED when granted i has lock[i]=1; LOCKED stays while owner req&lock=1; LOCKED -> BUSY/IDLE when owner drops lock or req, rr_ptr then = owner+1.
REQ-021 In LOCKED, gnt SHALL be owner only while owner req=1, all other requests stall; owner req=0 releases lock that cycle, no grant to owner.
REQ-022 Read then write to same address by one owner in consecutive LOCKED cycles SHALL return pre-write data on rvalid.
REQ-023 Simultaneous requests from all N_REQ SHALL each be granted within N_REQ cycles absent locks.

Reset
REQ-024 On reset: state=IDLE, rr_ptr=0, gnt=0, rvalid=0, rdata=0, wren=0, address=0, data=0; asynchronous assertion, release on clk edge.
REQ-025 Reset mid-LOCKED or mid-read SHALL drop the lock and suppress the pending rvalid.

Configuration
REQ-026 With SMEM_ARB_LOCK_EN defined, lock SHALL be honoured per REQ-020..022.
REQ-027 Without SMEM_ARB_LOCK_EN, lock SHALL be ignored, LOCKED SHALL be unreachable, round-robin re-arbitrates every cycle.

Structure
REQ-028 Package smem_pkg SHALL hold N_REQ, ADDR_W, DATA_W defaults, state enum (IDLE, BUSY, LOCKED), and requester index typedef.
REQ-029 One sub-module rr_pick SHALL implement the combinational rotating priority pick (req, rr_ptr -> one-hot, valid).

Verification
REQ-030 Reset: assert reset=1 mid-run -> gnt=0, rvalid=0, wren=0, address=0 immediately.
REQ-031 req=3'b111, lock=0, wr=0, addrs 8'h10/8'h20/8'h30 -> gnt 001,010,100,001 in consecutive cycles; rvalid follows one cycle later each.
REQ-032 Requester 1 writes 8'hA5 to 8'h42 -> wren=1, address=8'h42, data=8'hA5 that cycle; later read of 8'h42 -> rdata=8'hA5 with rvalid=3'b010.
REQ-033 (LOCK_EN) Requester 0 lock=1: read 8'h05 then write 8'h77 to 8'h05 while req[2]=1 -> gnt stays 001 for both cycles, rdata=old value, then gnt=100.
REQ-034 (no LOCK_EN) Same as REQ-033 stimulus -> gnt alternates 001,100; lock has no effect.
REQ-035 Reset asserted the cycle after a granted read -> no rvalid issued after release.
